// File: rtl/ti_key_matrix.sv
// ti_key_matrix: turns ps2_key toggle events into a ROWS x COLS key matrix.
// A loadable 512-entry scancode map sits between the keyboard and the matrix.
// Joystick channels are ORed onto dedicated columns.
// The console's active-low column strobes are answered with registered
// active-low row returns.
module ti_key_matrix #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int NJOY         = 2,
    parameter int JOY_BASE_COL = 6,
    localparam int RW          = $clog2(ROWS),
    localparam int CW          = $clog2(COLS),
    localparam int MW          = 2 + RW + CW
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [10:0]       ps2_key_i,
    input  logic              clear_i,
    input  logic              map_we_i,
    input  logic [8:0]        map_addr_i,
    input  logic [MW-1:0]     map_data_i,
    input  logic [5*NJOY-1:0] joy_i,
    input  logic [COLS-1:0]   sel_n_i,
    output logic [ROWS-1:0]   row_n_o,
    output logic              any_key_o
);

    localparam int NBITS = ROWS * COLS;

    // Scancode map, indexed by {ext, scancode}; deliberately not reset.
    logic [MW-1:0] map_mem [0:511];
    logic [MW-1:0] map_rd_q;

    // Stage 0 / stage 1 pipeline registers.
    logic       tog_q;
    logic       primed_q;
    logic       s1_valid_q;
    logic       s1_pressed_q;
    logic [8:0] rd_addr_q;
    logic       s2_valid_q;
    logic       s2_pressed_q;

    // Matrix and sticky lock state, flattened as bit r*COLS + c.
    logic [NBITS-1:0] matrix_q;
    logic [NBITS-1:0] matrix_d;
    logic [NBITS-1:0] lock_q;
    logic [NBITS-1:0] lock_d;
    logic [NBITS-1:0] hit;
    logic [NBITS-1:0] joy_ov;
    logic [NBITS-1:0] eff;
    logic [ROWS-1:0]  row_n_d;

    // Event detect. primed_q suppresses a spurious event from the reset-time tog_q.
    logic ev;
    assign ev = primed_q && (tog_q != ps2_key_i[10]);

    // Decoded fields of the map word in stage 2.
    logic          s2_map_valid;
    logic          s2_lock;
    logic [RW-1:0] s2_row;
    logic [CW-1:0] s2_col;
    logic          upd;

    assign s2_map_valid = map_rd_q[MW-1];
    assign s2_lock      = map_rd_q[MW-2];
    assign s2_row       = map_rd_q[CW +: RW];
    assign s2_col       = map_rd_q[0 +: CW];
    assign upd          = s2_valid_q && s2_map_valid;

    // Map RAM: write port plus registered read; read-during-write returns old data.
    always_ff @(posedge clk_i) begin
        if (map_we_i) begin
            map_mem[map_addr_i] <= map_data_i;
        end
        map_rd_q <= map_mem[rd_addr_q];
    end

    // Event pipeline: detect, latch address/pressed, carry pressed alongside the lookup.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tog_q        <= 1'b0;
            primed_q     <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_pressed_q <= 1'b0;
            rd_addr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_pressed_q <= 1'b0;
        end else begin
            tog_q      <= ps2_key_i[10];
            primed_q   <= 1'b1;
            s1_valid_q <= ev;
            if (ev) begin
                s1_pressed_q <= ps2_key_i[9];
                rd_addr_q    <= ps2_key_i[8:0];
            end
            s2_valid_q   <= s1_valid_q;
            s2_pressed_q <= s1_pressed_q;
        end
    end

    // Per-cell hit decode. Out-of-range row/col codes never match any cell, so they drop.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_hit
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col_hit
            assign hit[gi*COLS + gj] = upd && (s2_row == RW'(gi)) && (s2_col == CW'(gj));
        end
    end

    // Next matrix/lock state; clear overrides a coincident update.
    always_comb begin
        matrix_d = matrix_q;
        lock_d   = lock_q;
        if (clear_i) begin
            matrix_d = '0;
            lock_d   = '0;
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (hit[i]) begin
                    if (s2_lock) begin
                        lock_d[i]   = lock_q[i] ^ s2_pressed_q;
                        matrix_d[i] = lock_q[i] ^ s2_pressed_q;
                    end else begin
                        matrix_d[i] = s2_pressed_q;
                    end
                end
            end
        end
    end

    // Matrix and lock state registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            matrix_q <= '0;
            lock_q   <= '0;
        end else begin
            matrix_q <= matrix_d;
            lock_q   <= lock_d;
        end
    end

    // Joystick overlay: channel j drives column JOY_BASE_COL+j; joy bit k lands on row k.
    always_comb begin
        joy_ov = '0;
        for (int j = 0; j < NJOY; j++) begin
            for (int k = 0; k < 5; k++) begin
                joy_ov[k*COLS + JOY_BASE_COL + j] = joy_i[5*j + k];
            end
        end
    end

    assign eff = matrix_q | joy_ov;

    // A row returns low if any strobed column has an active cell in that row.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_out
        assign row_n_d[gi] = ~|(eff[gi*COLS +: COLS] & ~sel_n_i);
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            row_n_o   <= '1;
            any_key_o <= 1'b0;
        end else begin
            row_n_o   <= row_n_d;
            any_key_o <= |matrix_q;
        end
    end

endmodule

// File: tb/tb_ti_key_matrix.sv
// Scoreboard bench for ti_key_matrix: stimulus pushes expected outputs tagged with
// the cycle at which they must appear; a monitor compares them mid-cycle.
module tb_ti_key_matrix;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [10:0] ps2_key_i;
    logic        clear_i;
    logic        map_we_i;
    logic [8:0]  map_addr_i;
    logic [7:0]  map_data_i;
    logic [9:0]  joy_i;
    logic [7:0]  sel_n_i;
    logic [7:0]  row_n_o;
    logic        any_key_o;

    ti_key_matrix #(.ROWS(8), .COLS(8), .NJOY(2), .JOY_BASE_COL(6)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .ps2_key_i  (ps2_key_i),
        .clear_i    (clear_i),
        .map_we_i   (map_we_i),
        .map_addr_i (map_addr_i),
        .map_data_i (map_data_i),
        .joy_i      (joy_i),
        .sel_n_i    (sel_n_i),
        .row_n_o    (row_n_o),
        .any_key_o  (any_key_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] rn;
        logic       ak;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare every scoreboard entry whose cycle has come.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                checks++;
                if (row_n_o !== sb_q[i].rn || any_key_o !== sb_q[i].ak) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: row_n_o=%h any_key_o=%b, expected row_n_o=%h any_key_o=%b",
                             sb_q[i].nm, cyc, row_n_o, any_key_o, sb_q[i].rn, sb_q[i].ak);
                end else begin
                    $display("ok   %s cyc=%0d: row_n_o=%h any_key_o=%b", sb_q[i].nm, cyc, row_n_o, any_key_o);
                end
                sb_q.delete(i);
            end else if (sb_q[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: check for cyc=%0d was never sampled", sb_q[i].nm, sb_q[i].due);
                sb_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_at(input int d, input logic [7:0] rn, input logic ak, input string nm);
        exp_t e;
        e.due = cyc + d;
        e.rn  = rn;
        e.ak  = ak;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic map_wr(input logic [8:0] a, input logic [7:0] d);
        map_we_i   = 1'b1;
        map_addr_i = a;
        map_data_i = d;
        tick();
        map_we_i   = 1'b0;
    endtask

    // Flip the toggle bit and present a new key event (caller ticks).
    task automatic key(input logic ext, input logic pr, input logic [7:0] code);
        ps2_key_i = {~ps2_key_i[10], pr, ext, code};
    endtask

    initial begin
        reset_n_i  = 1'b0;
        ps2_key_i  = '0;
        clear_i    = 1'b0;
        map_we_i   = 1'b0;
        map_addr_i = '0;
        map_data_i = '0;
        joy_i      = '0;
        sel_n_i    = 8'hFF;

        // Reset state, even with strobes active.
        idle(2);
        sel_n_i = 8'h00;
        expect_at(1, 8'hFF, 1'b0, "reset");
        idle(2);
        sel_n_i = 8'hFF;
        reset_n_i = 1'b1;
        idle(2);

        // Map: {valid, lock, row[2:0], col[2:0]}
        map_wr(9'h01C, 8'h8D);  // row1 col5
        map_wr(9'h075, 8'h90);  // row2 col0
        map_wr(9'h175, 8'h00);  // invalid
        map_wr(9'h058, 8'hE7);  // lock, row4 col7
        map_wr(9'h015, 8'h80);  // row0 col0
        map_wr(9'h01D, 8'h9B);  // row3 col3
        map_wr(9'h024, 8'hAA);  // row5 col2
        map_wr(9'h02D, 8'hB4);  // row6 col4
        idle(2);

        // Basic key with exact latency.
        sel_n_i = 8'hDF;
        idle(2);
        key(1'b0, 1'b1, 8'h1C);
        expect_at(3, 8'hFF, 1'b0, "basic_early");
        expect_at(4, 8'hFD, 1'b1, "basic_press");
        tick();
        idle(5);
        key(1'b0, 1'b0, 8'h1C);
        expect_at(4, 8'hFF, 1'b0, "basic_release");
        tick();
        idle(5);

        // Extended distinction.
        sel_n_i = 8'hFE;
        idle(2);
        key(1'b1, 1'b1, 8'h75);
        expect_at(4, 8'hFF, 1'b0, "ext_e0_press");
        tick();
        idle(5);
        key(1'b0, 1'b1, 8'h75);
        expect_at(4, 8'hFB, 1'b1, "ext_plain_press");
        tick();
        idle(5);
        key(1'b0, 1'b0, 8'h75);
        expect_at(4, 8'hFF, 1'b0, "ext_plain_release");
        tick();
        idle(5);

        // Sticky lock key.
        sel_n_i = 8'h7F;
        idle(2);
        key(1'b0, 1'b1, 8'h58);
        expect_at(4, 8'hEF, 1'b1, "lock_press1");
        tick();
        idle(5);
        key(1'b0, 1'b0, 8'h58);
        expect_at(4, 8'hEF, 1'b1, "lock_release1");
        tick();
        idle(5);
        key(1'b0, 1'b1, 8'h58);
        expect_at(4, 8'hFF, 1'b0, "lock_press2");
        tick();
        idle(5);
        key(1'b0, 1'b0, 8'h58);
        expect_at(4, 8'hFF, 1'b0, "lock_release2");
        tick();
        idle(5);

        // Joystick overlay, one-cycle latency.
        sel_n_i = 8'h3F;
        joy_i   = 10'b00100_00001;
        expect_at(1, 8'hFA, 1'b0, "joy_overlay");
        tick();
        idle(2);
        joy_i = '0;
        expect_at(1, 8'hFF, 1'b0, "joy_off");
        tick();
        idle(2);

        // Back-to-back events, all columns strobed.
        sel_n_i = 8'h00;
        idle(2);
        key(1'b0, 1'b1, 8'h15);
        expect_at(4, 8'hFE, 1'b1, "b2b_first");
        tick();
        key(1'b0, 1'b1, 8'h1D);
        expect_at(4, 8'hF6, 1'b1, "b2b_second");
        tick();
        key(1'b0, 1'b1, 8'h24);
        expect_at(4, 8'hD6, 1'b1, "b2b_third");
        tick();
        idle(5);

        // Fourth key; clear_i coincides with its stage-2 update.
        key(1'b0, 1'b1, 8'h2D);
        expect_at(3, 8'hD6, 1'b1, "clear_before");
        expect_at(4, 8'hFF, 1'b0, "clear_wins");
        expect_at(7, 8'hFF, 1'b0, "clear_held");
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        idle(6);

        // Reset priming: toggle bit high through reset release.
        reset_n_i = 1'b0;
        ps2_key_i = {1'b1, 1'b1, 1'b0, 8'h1C};
        sel_n_i   = 8'hDF;
        expect_at(1, 8'hFF, 1'b0, "prime_in_reset");
        idle(3);
        reset_n_i = 1'b1;
        expect_at(2, 8'hFF, 1'b0, "prime_no_event_a");
        expect_at(5, 8'hFF, 1'b0, "prime_no_event_b");
        idle(7);
        ps2_key_i = {1'b0, 1'b1, 1'b0, 8'h1C};
        expect_at(4, 8'hFD, 1'b1, "prime_later_toggle");
        tick();
        idle(5);
        key(1'b0, 1'b0, 8'h1C);
        expect_at(4, 8'hFF, 1'b0, "prime_release");
        tick();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick();
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expected entries never checked, required 0", sb_q.size());
            errors += sb_q.size();
            checks += sb_q.size();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
